// File: rtl/puf_pkg.sv
// Constants and FSM encoding shared by the result-memory writer (test FSM)
// and the result reader.
package puf_pkg;

    localparam int RES_BASE_ADDR  = 1;
    localparam int RES_NUM_WORDS  = 8;
    localparam int RES_DATA_WIDTH = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_SEND,
        ST_CSUM,
        ST_DONE
    } rd_state_e;

endpackage

// File: rtl/puf_result_reader_if.sv
// Result-RAM read port plus the byte stream and status toward the SIRC handler.
interface puf_result_reader_if
    import puf_pkg::*;
#(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = RES_DATA_WIDTH
);
    logic                  mem_re;
    logic [ADDR_WIDTH-1:0] mem_raddr;
    logic [DATA_WIDTH-1:0] mem_dout;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic                  busy;
    logic                  rd_done;

    modport master (
        output mem_re, mem_raddr, tx_data, tx_valid, busy, rd_done,
        input  mem_dout, tx_ready
    );

    modport slave (
        input  mem_re, mem_raddr, tx_data, tx_valid, busy, rd_done,
        output mem_dout, tx_ready
    );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single level crossing into clk.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);
    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;
endmodule

// File: rtl/puf_result_reader.sv
// Reads NUM_WORDS pass counts from the result RAM after test_done rises and
// streams them, followed by a mod-2^DATA_WIDTH checksum byte.
module puf_result_reader
    import puf_pkg::*;
#(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = RES_DATA_WIDTH,
    parameter int BASE_ADDR  = RES_BASE_ADDR,
    parameter int NUM_WORDS  = RES_NUM_WORDS,
    parameter int RD_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 test_done,
    puf_result_reader_if.master  bus
);
    localparam int IDX_W = $clog2(NUM_WORDS + 1);

    if (BASE_ADDR + NUM_WORDS - 1 >= (1 << ADDR_WIDTH)) begin : g_addr_range_bad
        $error("puf_result_reader: BASE_ADDR+NUM_WORDS-1 exceeds ADDR_WIDTH");
    end
    if (RD_LATENCY < 1 || RD_LATENCY > 3) begin : g_latency_bad
        $error("puf_result_reader: RD_LATENCY must be 1..3");
    end

    logic w_td_sync;
    logic r_td_prev;
    logic w_start;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (test_done),
        .o_q   (w_td_sync)
    );

    assign w_start = w_td_sync & ~r_td_prev;

    rd_state_e             r_state,    w_state;
    logic [IDX_W-1:0]      r_idx,      w_idx;
    logic [DATA_WIDTH-1:0] r_csum,     w_csum;
    logic [1:0]            r_lat,      w_lat;
    logic                  r_mem_re,   w_mem_re;
    logic [ADDR_WIDTH-1:0] r_raddr,    w_raddr;
    logic [DATA_WIDTH-1:0] r_tx_data,  w_tx_data;
    logic                  r_tx_valid, w_tx_valid;
    logic                  r_busy,     w_busy;
    logic                  r_rd_done,  w_rd_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_td_prev  <= 1'b0;
            r_idx      <= '0;
            r_csum     <= '0;
            r_lat      <= '0;
            r_mem_re   <= 1'b0;
            r_raddr    <= '0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_rd_done  <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_td_prev  <= w_td_sync;
            r_idx      <= w_idx;
            r_csum     <= w_csum;
            r_lat      <= w_lat;
            r_mem_re   <= w_mem_re;
            r_raddr    <= w_raddr;
            r_tx_data  <= w_tx_data;
            r_tx_valid <= w_tx_valid;
            r_busy     <= w_busy;
            r_rd_done  <= w_rd_done;
        end
    end

    // Outputs are registered, so mem_re/raddr are loaded on the transition
    // into ISSUE and are therefore valid for exactly the ISSUE cycle.
    always_comb begin
        w_state    = r_state;
        w_idx      = r_idx;
        w_csum     = r_csum;
        w_lat      = r_lat;
        w_mem_re   = 1'b0;
        w_raddr    = r_raddr;
        w_tx_data  = r_tx_data;
        w_tx_valid = r_tx_valid;
        w_busy     = r_busy;
        w_rd_done  = r_rd_done;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state   = ST_ISSUE;
                    w_idx     = '0;
                    w_csum    = '0;
                    w_busy    = 1'b1;
                    w_rd_done = 1'b0;
                    w_mem_re  = 1'b1;
                    w_raddr   = ADDR_WIDTH'(BASE_ADDR);
                end
            end
            ST_ISSUE: begin
                w_lat   = 2'(RD_LATENCY);
                w_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (r_lat <= 2'd1) begin
                    w_tx_data  = bus.mem_dout;
                    w_tx_valid = 1'b1;
                    w_state    = ST_SEND;
                end else begin
                    w_lat = r_lat - 2'd1;
                end
            end
            ST_SEND: begin
                if (bus.tx_ready) begin
                    w_csum     = r_csum + r_tx_data;
                    w_idx      = r_idx + 1'b1;
                    w_tx_valid = 1'b0;
                    if (r_idx == IDX_W'(NUM_WORDS - 1)) begin
                        w_state = ST_CSUM;
                    end else begin
                        w_state  = ST_ISSUE;
                        w_mem_re = 1'b1;
                        w_raddr  = ADDR_WIDTH'(BASE_ADDR + int'(r_idx) + 1);
                    end
                end
            end
            ST_CSUM: begin
                if (!r_tx_valid) begin
                    w_tx_data  = r_csum;
                    w_tx_valid = 1'b1;
                end else if (bus.tx_ready) begin
                    w_tx_valid = 1'b0;
                    w_busy     = 1'b0;
                    w_rd_done  = 1'b1;
                    w_state    = ST_DONE;
                end
            end
            ST_DONE: begin
                w_rd_done = 1'b1;
                if (!w_td_sync) begin
                    w_rd_done = 1'b0;
                    w_state   = ST_IDLE;
                end
            end
            default: w_state = ST_IDLE;
        endcase
    end

    assign bus.mem_re    = r_mem_re;
    assign bus.mem_raddr = r_raddr;
    assign bus.tx_data   = r_tx_data;
    assign bus.tx_valid  = r_tx_valid;
    assign bus.busy      = r_busy;
    assign bus.rd_done   = r_rd_done;
endmodule
